// File: rtl/parking_time_display.sv
`timescale 1ns/1ps
// parking_time_display
// -----------------------------------------------------------------------------
// Converts the 12-bit elapsed-seconds count from the parking second counter into
// MM:SS digits with an iterative subtract-only converter (no dividers), then
// scans them onto a 4-digit multiplexed common-anode seven-segment display.
// The display blanks while no car is parked; conversion and scanning keep
// running underneath so digits are already current when a car arrives.
//
// Parameters
//   REFRESH_DIV  master-clock cycles each digit stays lit (>= 2)
//
// Ports
//   clk        in   master clock, rising edge
//   rst_n      in   synchronous active-low reset
//   sec_count  in   [11:0] elapsed seconds, quasi-static
//   parked     in   1 = car present, display enabled
//   seg        out  [6:0] segment cathodes {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal-point cathode (MM:SS colon), active-low
//   an         out  [3:0] digit anodes, active-low (3 = min tens .. 0 = sec ones)
//   conv_done  out  one-cycle pulse when new digits are committed
//
// Build option
//   COLON_BLINK_EN  colon lit only while bit 0 of the committed count is 0
//                   (blinks at 0.5 Hz); otherwise the colon is lit steadily.
// -----------------------------------------------------------------------------
module parking_time_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] sec_count,
    input  logic        parked,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        conv_done
);

    localparam int NUM_DIGITS = 4;
    localparam int CW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MIN    = 2'd1,
        SPLIT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Active-low gfedcba pattern for one decimal digit; non-decimal codes blank.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------- converter
    state_t                           state_q, state_d;
    logic [11:0]                      snap_q, snap_d;     // last sample taken
    logic [11:0]                      work_q, work_d;     // remaining seconds
    logic [6:0]                       minute_q, minute_d; // minutes, then min ones
    logic [3:0]                       min_tens_q, min_tens_d;
    logic [3:0]                       sec_tens_q, sec_tens_d;
    logic [NUM_DIGITS-1:0][3:0]       digit_q, digit_d;   // committed digits
    logic                             done_d;

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        work_d     = work_q;
        minute_d   = minute_q;
        min_tens_d = min_tens_q;
        sec_tens_d = sec_tens_q;
        digit_d    = digit_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // Inputs are only sampled here, so a conversion always works on
                // a single consistent value.
                if (sec_count != snap_q) begin
                    snap_d     = sec_count;
                    work_d     = sec_count;
                    minute_d   = '0;
                    min_tens_d = '0;
                    sec_tens_d = '0;
                    state_d    = MIN;
                end
            end
            MIN: begin
                if (work_q >= 12'd60) begin
                    work_d   = work_q - 12'd60;
                    minute_d = minute_q + 7'd1;
                end else begin
                    state_d = SPLIT;
                end
            end
            SPLIT: begin
                // Minutes and seconds are peeled into tens in parallel; the
                // longer of the two sets the number of SPLIT cycles.
                if (minute_q >= 7'd10) begin
                    minute_d   = minute_q - 7'd10;
                    min_tens_d = min_tens_q + 4'd1;
                end
                if (work_q >= 12'd10) begin
                    work_d     = work_q - 12'd10;
                    sec_tens_d = sec_tens_q + 4'd1;
                end
                if (minute_q < 7'd10 && work_q < 12'd10) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // Both remainders are < 10 here, so the low nibbles are the ones digits.
                digit_d = {min_tens_q, minute_q[3:0], sec_tens_q, work_q[3:0]};
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            work_q     <= '0;
            minute_q   <= '0;
            min_tens_q <= '0;
            sec_tens_q <= '0;
            digit_q    <= '0;
            conv_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            work_q     <= work_d;
            minute_q   <= minute_d;
            min_tens_q <= min_tens_d;
            sec_tens_q <= sec_tens_d;
            digit_q    <= digit_d;
            conv_done  <= done_d;
        end
    end

    // ---------------------------------------------------------------- colon
    logic colon_on;
`ifdef COLON_BLINK_EN
    // Tracks the count that is actually on the display, not the one being
    // converted, so the colon phase never runs ahead of the digits.
    logic shown_lsb_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shown_lsb_q <= 1'b0;
        end else if (state_q == COMMIT) begin
            shown_lsb_q <= snap_q[0];
        end
    end
    assign colon_on = ~shown_lsb_q;
`else
    assign colon_on = 1'b1;
`endif

    // ---------------------------------------------------------------- scanning
    logic [CW-1:0] ref_cnt_q;
    logic [1:0]    idx_q;
    logic          ref_wrap;

    assign ref_wrap = (ref_cnt_q == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
            idx_q     <= '0;
        end else if (ref_wrap) begin
            ref_cnt_q <= '0;
            idx_q     <= idx_q + 2'd1;
        end else begin
            ref_cnt_q <= ref_cnt_q + CW'(1);
        end
    end

    // One decoder per digit; the scan index then just selects a pattern.
    logic [NUM_DIGITS-1:0][6:0] seg_lut;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        assign seg_lut[i] = seg_enc(digit_q[i]);
    end

    // Registered drivers keep the pad outputs glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= 7'b1111111;
            an  <= 4'b1111;
            dp  <= 1'b1;
        end else begin
            seg <= seg_lut[idx_q];
            an  <= parked ? ~(4'b0001 << idx_q) : 4'b1111;
            dp  <= ~(parked && (idx_q == 2'd2) && colon_on);
        end
    end

endmodule

// File: doc/parking_time_display.md
# parking_time_display

Display stage downstream of the parking second counter. Consumes the 12-bit elapsed-seconds count, converts it sequentially to MM:SS decimal digits, and drives a 4-digit multiplexed common-anode seven-segment display. The display blanks while no car is parked. Runs on the board master clock; the converter is iterative to avoid dividers.

## Interface
- `REFRESH_DIV`, default 100000: master-clock cycles each digit stays lit (1 kHz digit rate at 100 MHz); minimum 2.
- `clk` input 1: master clock; all logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `sec_count` input 12: elapsed seconds from the second counter, 0..4095; treated as quasi-static.
- `parked` input 1: high = car present, display enabled.
- `seg` output 7: segment cathodes {g,f,e,d,c,b,a}, active-low.
- `dp` output 1: decimal point cathode, active-low; used as the MM:SS colon.
- `an` output 4: digit anodes, active-low; an[3]=min tens, an[2]=min ones, an[1]=sec tens, an[0]=sec ones.
- `conv_done` output 1: one-cycle pulse when new digits are committed.

## Operation
- Reset values: state IDLE, snapshot 0, all four digit registers 0, refresh counter 0, digit index 0, `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `conv_done`=0.
- FSM states:
  - IDLE: if `sec_count` != snapshot, latch `sec_count` into snapshot and a 12-bit work register, clear the minute count, go to MIN. Otherwise stay.
  - MIN: if work >= 60, work -= 60 and minute += 1, stay. Otherwise go to SPLIT; work now holds seconds 0..59 and minute holds 0..68.
  - SPLIT: minute and seconds split in parallel. Each field >= 10 subtracts 10 and increments its tens digit in the same cycle. When both fields are < 10, go to COMMIT.
  - COMMIT: write the four digit registers together, pulse `conv_done`, go to IDLE.
- A change on `sec_count` outside IDLE is ignored. It is picked up at the next IDLE cycle, so the displayed value is never a mix of two samples.
- Refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→3→0. Index i selects `an[i]` and digit register i.
- Segment encoding (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- `parked`=0: `an`=4'b1111 and `dp`=1. The FSM and refresh counter keep running, so digits are already current when `parked` rises.
- `dp` is driven low only when index 2 is active and `parked`=1, subject to Configuration.
- Widths: work register 12 bits; minute 7 bits; each digit 4 bits. Minute tens never exceeds 6.

## Timing
- Conversion latency, counted from the IDLE latch edge to the `conv_done` cycle: floor(v/60) + max(floor(m/10), floor(s/10)) + 4 cycles.
  - v=0: 4. v=60: 5. v=4095 (68:15): 78 worst case.
- Digit registers update on the COMMIT edge and are seen on the next refresh slot of each digit.
- `seg`, `an` and `dp` are registered: one cycle after the index or digit register changes.
- Reset mid-conversion aborts and returns to IDLE with snapshot 0. If `sec_count` is nonzero, conversion restarts on the first cycle after `rst_n` rises.
- `sec_count`=0 after reset triggers no conversion; the display already shows 00:00.

## Configuration
- `COLON_BLINK_EN` defined: colon `dp` is lit only while bit 0 of the committed snapshot is 0, so it blinks at 0.5 Hz with the 1 Hz count.
- Not defined: colon is lit steadily whenever index 2 is active and `parked`=1.

## Test plan
- Reset with `sec_count`=0, `parked`=1, REFRESH_DIV=4 → no `conv_done`; `an` cycles 1110, 1101, 1011, 0111 every 4 cycles; `seg`=1000000 on every digit.
- `sec_count`=4095 → `conv_done` exactly 78 cycles after latch; digits 6,8,1,5; an[3] slot shows seg 0000010.
- `sec_count`=59, then 60 → digits 0,0,5,9, then 0,1,0,0; latencies 9 and 5.
- Change `sec_count` 125→3000 mid-conversion → first commit shows 02:05, second commit shows 50:00; no mixed digits.
- `parked`=0 for 20 cycles → `an`=1111 and `dp`=1 throughout; raising `parked` shows current digits on the next slot.
- Assert `rst_n`=0 during MIN for `sec_count`=4095 → all outputs return to reset values. After release, conversion reruns and commits 68:15. Repeat with and without `COLON_BLINK_EN`, checking `dp` on an[2] for values 4094 and 4095.
